// File: rtl/fsmseq_pkg.sv
// fsmseq_pkg: shared sequencer states, detector state codes, error codes and w-detector reference transition
package fsmseq_pkg;
  typedef enum logic [2:0] {IDLE, RST, RCHK, APPLY, STEP, CHECK, DONE, ERR} seq_state_t;
  localparam logic [2:0] ST_A = 3'd0;
  localparam logic [2:0] ST_B = 3'd1;
  localparam logic [2:0] ST_C = 3'd2;
  localparam logic [2:0] ST_D = 3'd3;
  localparam logic [2:0] ST_E = 3'd4;
  localparam logic [2:0] EC_NONE   = 3'b000;
  localparam logic [2:0] EC_ONEHOT = 3'b001;
  localparam logic [2:0] EC_STATE  = 3'b010;
  localparam logic [2:0] EC_Z      = 3'b011;
  localparam logic [2:0] EC_GOLDEN = 3'b100;
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic w);
    return w ? ((s == ST_D || s == ST_E) ? ST_E : ST_D)
             : ((s == ST_B || s == ST_C) ? ST_C : ST_B);
  endfunction
  function automatic logic det_z(input logic [2:0] s);
    return s == ST_C || s == ST_E;
  endfunction
endpackage

// File: rtl/onehot_to_bin.sv
// onehot_to_bin: 5-bit one-hot detector state to 3-bit index, valid when exactly one bit is set
module onehot_to_bin (
  input  logic [4:0] onehot,
  output logic [2:0] index,
  output logic       valid
);
  assign valid = (onehot != 5'd0) && ((onehot & (onehot - 5'd1)) == 5'd0);
  assign index = onehot[4] ? 3'd4 : onehot[3] ? 3'd3 : onehot[2] ? 3'd2 : onehot[1] ? 3'd1 : 3'd0;
endmodule

// File: rtl/fsm_lockstep_sequencer.sv
// fsm_lockstep_sequencer: steps one-hot and binary w-detectors through a stored pattern and cross-checks them.
// FSMSEQ_GOLDEN_EN adds an internal reference detector checked after every step (error code 100).
module fsm_lockstep_sequencer
  import fsmseq_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  output logic               w,
  output logic               step,
  output logic               fsm_reset,
  input  logic [4:0]         onehot_state,
  input  logic [2:0]         binary_state,
  input  logic               z_onehot,
  input  logic               z_binary,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         error_code,
  output logic [LEN_W-1:0]   fail_step,
  output logic [LEN_W-1:0]   step_count
);
  localparam int IDX_W = $clog2(MAX_LEN);
  seq_state_t state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0] len_q, idx, idx_nxt;
  logic [2:0] oh_index, rchk_code, chk_code, golden_code;
  logic oh_valid;
  onehot_to_bin u_oh (.onehot(onehot_state), .index(oh_index), .valid(oh_valid));
  assign idx_nxt = idx + LEN_W'(1);
  assign rchk_code = !oh_valid ? EC_ONEHOT
                   : (oh_index != ST_A || binary_state != ST_A) ? EC_STATE
                   : (z_onehot || z_binary) ? EC_Z : EC_NONE;
  assign chk_code = !oh_valid ? EC_ONEHOT
                  : oh_index != binary_state ? EC_STATE
                  : z_onehot != z_binary ? EC_Z : golden_code;
`ifdef FSMSEQ_GOLDEN_EN
  logic [2:0] gold;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) gold <= ST_A;
    else if (state == RST) gold <= ST_A;
    else if (state == STEP) gold <= det_next(gold, w);
  assign golden_code = (binary_state != gold || z_binary != det_z(gold)) ? EC_GOLDEN : EC_NONE;
`else
  assign golden_code = EC_NONE;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      pattern_q  <= '0;
      len_q      <= '0;
      idx        <= '0;
      w          <= 1'b0;
      step       <= 1'b0;
      fsm_reset  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= EC_NONE;
      fail_step  <= '0;
      step_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pattern_q  <= pattern;
          len_q      <= (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
          idx        <= '0;
          done       <= 1'b0;
          error      <= 1'b0;
          error_code <= EC_NONE;
          fail_step  <= '0;
          step_count <= '0;
          fsm_reset  <= 1'b1;
          busy       <= 1'b1;
          state      <= RST;
        end
        RST: begin
          fsm_reset <= 1'b0;
          state     <= RCHK;
        end
        RCHK: if (rchk_code != EC_NONE) begin
          error      <= 1'b1;
          error_code <= rchk_code;
          fail_step  <= '0;
          busy       <= 1'b0;
          state      <= ERR;
        end else if (len_q == '0) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end else state <= APPLY;
        APPLY: begin
          w     <= pattern_q[idx[IDX_W-1:0]];
          step  <= 1'b1;
          state <= STEP;
        end
        STEP: begin
          step  <= 1'b0;
          state <= CHECK;
        end
        CHECK: if (chk_code != EC_NONE) begin
          error      <= 1'b1;
          error_code <= chk_code;
          fail_step  <= idx_nxt;
          busy       <= 1'b0;
          state      <= ERR;
        end else begin
          step_count <= idx_nxt;
          if (idx_nxt == len_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx   <= idx_nxt;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
